// File: rtl/vend_core_param_if.sv
// Dispenser and coin-hopper handshakes of the vending core.
// A transfer happens on every rising clock edge where valid and ready are both high; valid never waits on ready, payload stays stable while valid is high and ready is low, and ready may toggle freely.
interface vend_core_param_if #(
    parameter int ITEM_W = 3
);
    logic              vend_valid;
    logic [ITEM_W-1:0] vend_item;
    logic              vend_ready;
    logic              chg_valid;
    logic [2:0]        chg_coin;
    logic              chg_ready;

    modport master (
        output vend_valid, vend_item, chg_valid, chg_coin,
        input  vend_ready, chg_ready
    );

    modport slave (
        input  vend_valid, vend_item, chg_valid, chg_coin,
        output vend_ready, chg_ready
    );
endinterface

// File: rtl/vend_core_param.sv
// Parametrised vending controller: coin crediting, item vend handshake,
// greedy change return and inactivity auto-refund. All outputs registered.
module vend_core_param #(
    parameter int                            NUM_ITEMS   = 8,
    parameter int                            ITEM_W      = 3,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {8'd25, 8'd20, 8'd15, 8'd12,
                                                            8'd10, 8'd8,  8'd5,  8'd3},
    parameter int                            COIN_V0     = 1,
    parameter int                            COIN_V1     = 5,
    parameter int                            COIN_V2     = 10,
    parameter int                            CREDIT_MAX  = 99,
    parameter int                            TIMEOUT_CYC = 1500000000,
    parameter bit                            AUTO_CHANGE = 1'b1
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic [2:0]          coin_in,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    input  logic                cancel,
    vend_core_param_if.master   bus,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CREDIT_W-1:0] V0 = CREDIT_W'(COIN_V0);
    localparam logic [CREDIT_W-1:0] V1 = CREDIT_W'(COIN_V1);
    localparam logic [CREDIT_W-1:0] V2 = CREDIT_W'(COIN_V2);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t              state_q, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic                vend_valid_q, vend_valid_n;
    logic [ITEM_W-1:0]   vend_item_q, vend_item_n;
    logic                chg_valid_q, chg_valid_n;
    logic [2:0]          chg_coin_q, chg_coin_n;
    logic                coin_reject_q, coin_reject_n;
    logic                sel_err_q, sel_err_n;
    logic                busy_q, busy_n;
    logic [TW-1:0]       tmo_q, tmo_n;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] c);
        case (c)
            3'b001:  coin_value = V0;
            3'b010:  coin_value = V1;
            3'b100:  coin_value = V2;
            default: coin_value = '0;
        endcase
    endfunction

    // Largest denomination not exceeding the balance; ties keep the lower input.
    function automatic logic [2:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        logic [CREDIT_W-1:0] best;
        best        = '0;
        greedy_coin = '0;
        if (V0 <= c && V0 > best) begin best = V0; greedy_coin = 3'b001; end
        if (V1 <= c && V1 > best) begin best = V1; greedy_coin = 3'b010; end
        if (V2 <= c && V2 > best) begin best = V2; greedy_coin = 3'b100; end
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        price_of = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (idx == ITEM_W'(i)) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
    endfunction

    logic                coin_onehot, sel_ok, coin_ok;
    logic [CREDIT_W-1:0] coin_val, sel_price, coin_base, chg_left;
    logic [CREDIT_W:0]   coin_sum;

    assign coin_onehot = (coin_in == 3'b001) || (coin_in == 3'b010) || (coin_in == 3'b100);
    assign coin_val    = coin_value(coin_in);
    assign sel_price   = price_of(sel_item);
    assign sel_ok      = sel_valid && ({1'b0, sel_item} < (ITEM_W+1)'(NUM_ITEMS))
                         && (sel_price <= credit_q);
    // A coin riding along with an accepted select lands on the post-deduction balance.
    assign coin_base   = sel_ok ? credit_q - sel_price : credit_q;
    assign coin_sum    = {1'b0, coin_base} + {1'b0, coin_val};
    assign coin_ok     = coin_onehot && (coin_sum <= (CREDIT_W+1)'(CREDIT_MAX));
    assign chg_left    = credit_q - coin_value(chg_coin_q);

    always_comb begin
        state_n       = state_q;
        credit_n      = credit_q;
        vend_valid_n  = vend_valid_q;
        vend_item_n   = vend_item_q;
        chg_valid_n   = chg_valid_q;
        chg_coin_n    = chg_coin_q;
        coin_reject_n = 1'b0;
        sel_err_n     = 1'b0;
        tmo_n         = '0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel) begin
                    coin_reject_n = |coin_in;
                    if (state_q == S_CREDIT) begin
                        state_n     = S_CHANGE;
                        chg_valid_n = 1'b1;
                        chg_coin_n  = greedy_coin(credit_q);
                    end
                end else if (sel_ok) begin
                    credit_n      = coin_ok ? coin_sum[CREDIT_W-1:0] : coin_base;
                    coin_reject_n = (|coin_in) && !coin_ok;
                    vend_item_n   = sel_item;
                    vend_valid_n  = 1'b1;
                    state_n       = S_VEND;
                end else begin
                    sel_err_n     = sel_valid;
                    coin_reject_n = (|coin_in) && !coin_ok;
                    if (coin_ok) credit_n = coin_sum[CREDIT_W-1:0];
                    state_n = (credit_n != '0) ? S_CREDIT : S_IDLE;
                    if (state_q == S_CREDIT && coin_in == 3'b000 && !sel_valid) begin
                        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                            state_n     = S_CHANGE;
                            chg_valid_n = 1'b1;
                            chg_coin_n  = greedy_coin(credit_q);
                        end else begin
                            tmo_n = tmo_q + 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                coin_reject_n = |coin_in;
                if (bus.vend_ready) begin
                    vend_valid_n = 1'b0;
                    if (credit_q == '0) begin
                        state_n = S_IDLE;
                    end else if (AUTO_CHANGE) begin
                        state_n     = S_CHANGE;
                        chg_valid_n = 1'b1;
                        chg_coin_n  = greedy_coin(credit_q);
                    end else begin
                        state_n = S_CREDIT;
                    end
                end
            end
            S_CHANGE: begin
                coin_reject_n = |coin_in;
                if (bus.chg_ready) begin
                    credit_n   = chg_left;
                    chg_coin_n = greedy_coin(chg_left);
                    if (chg_left == '0) begin
                        state_n     = S_IDLE;
                        chg_valid_n = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            vend_item_q   <= '0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_n;
            credit_q      <= credit_n;
            vend_valid_q  <= vend_valid_n;
            vend_item_q   <= vend_item_n;
            chg_valid_q   <= chg_valid_n;
            chg_coin_q    <= chg_coin_n;
            coin_reject_q <= coin_reject_n;
            sel_err_q     <= sel_err_n;
            busy_q        <= busy_n;
            tmo_q         <= tmo_n;
        end
    end

    assign bus.vend_valid = vend_valid_q;
    assign bus.vend_item  = vend_item_q;
    assign bus.chg_valid  = chg_valid_q;
    assign bus.chg_coin   = chg_coin_q;
    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign sel_err        = sel_err_q;
    assign busy           = busy_q;
    assign state_dbg      = state_q;
endmodule
